// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_pkg
// Brief    : Image geometry, derived address widths and sequencer state codes
//            shared by the CNN image-buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int K     = 3;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : img_pkg
`default_nettype wire

// File: rtl/rc_counter.sv
`default_nettype none
// ============================================================================
// Module   : rc_counter
// Brief    : Row/column address counter; column wraps at COL_LAST and carries
//            into the row, 'last' flags the final (ROW_LAST, COL_LAST) cell.
// Revision : 1.0 - initial release
// ============================================================================
module rc_counter #(
    parameter int ROW_W    = 5,
    parameter int COL_W    = 5,
    parameter int ROW_LAST = 31,
    parameter int COL_LAST = 31
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(ROW_LAST);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(COL_LAST);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_last;
    logic             w_row_last;

    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);

    // clear wins over inc so a restart always begins at cell (0,0)
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = w_col_last & w_row_last;

endmodule : rc_counter
`default_nettype wire

// File: rtl/img_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : img_buf_ctrl
// Brief    : Loads one image from a valid/ready pixel stream into the buffer,
//            then scans it as K-row column slices for the PE array.
// Revision : 1.0 - initial release
// ============================================================================
module img_buf_ctrl #(
    parameter int IMG_W = img_pkg::IMG_W,
    parameter int IMG_H = img_pkg::IMG_H,
    parameter int K     = img_pkg::K,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pe_ready,
    output logic             buf_en,
    output logic             wr,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic             rd,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic             win_valid,
    output logic             busy,
    output logic             done
);

    import img_pkg::*;

    state_t r_state;
    state_t w_next;

    logic w_in_ready;
    logic w_wr;
    logic w_rd;
    logic w_done;
    logic w_wr_clear;
    logic w_rd_clear;
    logic w_wr_last;
    logic w_rd_last;
    logic r_win_valid;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_wr       = 1'b0;
        w_rd       = 1'b0;
        w_done     = 1'b0;
        w_wr_clear = 1'b0;
        w_rd_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next     = LOAD;
                    w_wr_clear = 1'b1;
                end
            end
            LOAD: begin
                w_in_ready = 1'b1;
                w_wr       = in_valid;
                if (in_valid && w_wr_last) begin
                    w_next     = SCAN;
                    w_rd_clear = 1'b1;
                end
            end
            SCAN: begin
                w_rd = pe_ready;
                if (pe_ready && w_rd_last) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Buffer read data appears one cycle after the read strobe
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= w_rd;
        end
    end

    rc_counter #(
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .ROW_LAST (IMG_H - 1),
        .COL_LAST (IMG_W - 1)
    ) u_wr_cnt (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (w_wr_clear),
        .inc     (w_wr),
        .row     (wr_row),
        .col     (wr_col),
        .last    (w_wr_last)
    );

    // Top slice row stops at IMG_H-K so the K-row window stays inside the image
    rc_counter #(
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .ROW_LAST (IMG_H - K),
        .COL_LAST (IMG_W - 1)
    ) u_rd_cnt (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (w_rd_clear),
        .inc     (w_rd),
        .row     (rd_row),
        .col     (rd_col),
        .last    (w_rd_last)
    );

    assign in_ready  = w_in_ready;
    assign wr        = w_wr;
    assign rd        = w_rd;
    assign buf_en    = w_wr | w_rd;
    assign win_valid = r_win_valid;
    assign busy      = (r_state != IDLE);
    assign done      = w_done;

endmodule : img_buf_ctrl
`default_nettype wire

// File: tb/tb_img_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_buf_ctrl
// Brief    : Scoreboard bench for img_buf_ctrl: expected write/read address
//            sequences are queued per frame and consumed as strobes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_buf_ctrl;

    import img_pkg::*;

    localparam int RD_ROWS = IMG_H - K + 1;
    localparam int N_WR    = IMG_W * IMG_H;
    localparam int N_RD    = RD_ROWS * IMG_W;
    localparam int LIMIT   = 8000;

    typedef logic [ROW_W+COL_W-1:0] addr_t;

    logic             sys_clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             pe_ready;
    logic             buf_en;
    logic             wr;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic             rd;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic             win_valid;
    logic             busy;
    logic             done;

    img_buf_ctrl dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pe_ready  (pe_ready),
        .buf_en    (buf_en),
        .wr        (wr),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .rd        (rd),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .win_valid (win_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    addr_t exp_wr[$];
    addr_t exp_rd[$];
    int    wr_cnt, rd_cnt, win_cnt, done_cnt;
    int    start_cyc, first_rd_cyc, last_rd_cyc, done_cyc;
    addr_t last_rd_addr;
    bit    prev_rd = 1'b0;

    always @(posedge sys_clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  0);
        check_eq({tag, "_buf_en"},    32'(buf_en),    0);
        check_eq({tag, "_wr"},        32'(wr),        0);
        check_eq({tag, "_rd"},        32'(rd),        0);
        check_eq({tag, "_win_valid"}, 32'(win_valid), 0);
        check_eq({tag, "_busy"},      32'(busy),      0);
        check_eq({tag, "_done"},      32'(done),      0);
        check_eq({tag, "_wr_addr"},   32'({wr_row, wr_col}), 0);
        check_eq({tag, "_rd_addr"},   32'({rd_row, rd_col}), 0);
    endtask

    // Monitor / scoreboard consumer
    always @(negedge sys_clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            check_eq("buf_en", 32'(buf_en), 32'(wr | rd));
            if (wr | rd) check_eq("wr_rd_excl", 32'(wr & rd), 0);
            check_eq("win_valid_lat", 32'(win_valid), 32'(prev_rd));
            if (win_valid) win_cnt++;
            if (wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) check_eq("wr_extra", 1, 0);
                else check_eq("wr_addr", 32'({wr_row, wr_col}), 32'(exp_wr.pop_front()));
            end
            if (rd) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc  = cyc;
                last_rd_addr = {rd_row, rd_col};
                if (exp_rd.size() == 0) check_eq("rd_extra", 1, 0);
                else check_eq("rd_addr", 32'({rd_row, rd_col}), 32'(exp_rd.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (start && !busy) start_cyc = cyc;
            prev_rd = rd;
        end
    end

    task automatic frame_prep();
        exp_wr.delete();
        exp_rd.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                exp_wr.push_back({ROW_W'(r), COL_W'(c)});
        for (int r = 0; r < RD_ROWS; r++)
            for (int c = 0; c < IMG_W; c++)
                exp_rd.push_back({ROW_W'(r), COL_W'(c)});
        wr_cnt = 0; rd_cnt = 0; win_cnt = 0; done_cnt = 0;
        start_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1; done_cyc = -1;
    endtask

    // pe_mode: 0 = always ready, 1 = toggling, 2 = 5-cycle stall at (10,7)
    task automatic run_frame(input bit gapped, input int pe_mode, input bit poke,
                             input int abort_row, output bit aborted);
        bit finished = 1'b0;
        bit bp_done  = 1'b0;
        int bp_cnt   = 0;
        aborted = 1'b0;
        frame_prep();
        @(posedge sys_clk); #1;
        start = 1'b1;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge sys_clk); #1;
            start = 1'b0;
            if (done) begin
                finished = 1'b1;
                if (poke) start = 1'b1;
                break;
            end
            if (abort_row >= 0 && busy && !in_ready && int'(rd_row) == abort_row) begin
                aborted = 1'b1;
                break;
            end
            in_valid = gapped ? (k % 3 == 0) : 1'b1;
            if (pe_mode == 1) pe_ready = (k % 2 == 0);
            else              pe_ready = 1'b1;
            if (pe_mode == 2 && !bp_done && busy && !in_ready && rd_row == 10 && rd_col == 7) begin
                bp_done = 1'b1;
                bp_cnt  = 5;
            end
            if (bp_cnt > 0) begin
                pe_ready = 1'b0;
                @(negedge sys_clk);
                check_eq("bp_rd",   32'(rd), 0);
                check_eq("bp_addr", 32'({rd_row, rd_col}), 32'({5'd10, 5'd7}));
                bp_cnt--;
            end
            if (poke && (k == 100 || (rd_row == 5 && rd_col == 0 && busy && !in_ready)))
                start = 1'b1;
        end
        in_valid = 1'b0;
        if (aborted) return;
        check_eq("frame_timeout", 32'(finished), 1);
        if (pe_mode == 2) check_eq("bp_seen", 32'(bp_done), 1);
        if (poke) begin
            @(posedge sys_clk); #1;
            start = 1'b0;
            check_eq("start_in_done_ignored", 32'(busy), 0);
        end
        @(posedge sys_clk); #1;
        check_eq("idle_after_done", 32'(busy | in_ready), 0);
        check_eq("wr_count",     32'(wr_cnt),   N_WR);
        check_eq("rd_count",     32'(rd_cnt),   N_RD);
        check_eq("win_count",    32'(win_cnt),  N_RD);
        check_eq("done_count",   32'(done_cnt), 1);
        check_eq("done_latency", 32'(done_cyc - last_rd_cyc), 2);
        check_eq("last_rd_addr", 32'(last_rd_addr), 32'({ROW_W'(IMG_H - K), COL_W'(IMG_W - 1)}));
        check_eq("wr_left",      32'(exp_wr.size()), 0);
        check_eq("rd_left",      32'(exp_rd.size()), 0);
        if (!gapped && pe_mode != 1)
            check_eq("scan_entry", 32'(first_rd_cyc - start_cyc), N_WR + 1);
    endtask

    initial begin
        bit ab;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; pe_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge sys_clk); #1;
        check_idle("post_reset");

        run_frame(1'b0, 0, 1'b1, -1, ab);   // basic, with stray starts
        run_frame(1'b1, 1, 1'b0, -1, ab);   // gapped input, toggling pe_ready
        run_frame(1'b0, 2, 1'b0, -1, ab);   // PE backpressure

        run_frame(1'b0, 0, 1'b0, 15, ab);   // abort mid-scan
        check_eq("abort_reached", 32'(ab), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(posedge sys_clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("abort_no_done", 32'(done_cnt), 0);
        check_idle("after_abort");

        run_frame(1'b0, 0, 1'b0, -1, ab);   // fresh load after abort

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_img_buf_ctrl
`default_nettype wire

// File: doc/img_buf_ctrl.md
Name: img_buf_ctrl

Overview:
- Sequencer for the CNN image buffer.
- Loads one IMG_H x IMG_W 8-bit image from a valid/ready pixel stream into the buffer in row-major order.
- Then scans it as K-row column slices, one column per beat, for the weight-stationary PE array.
- Generates buffer enable, write/read strobes and row/column addresses; handshakes with the stream source and the PE array.

Parameters:
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.
- K, 3, kernel height; rows presented per read beat (rd_row .. rd_row+K-1).
- COL_W, $clog2(IMG_W), column address width (derived).
- ROW_W, $clog2(IMG_H), row address width (derived).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin load+scan; honoured only in IDLE.
- in_valid  in  1  source pixel valid.
- in_ready  out  1  controller accepts a pixel this cycle.
- pe_ready  in  1  PE array can take a column slice this cycle.
- buf_en  out  1  buffer enable.
- wr  out  1  buffer write strobe.
- wr_row  out  ROW_W  write row address.
- wr_col  out  COL_W  write column address.
- rd  out  1  buffer read strobe.
- rd_row  out  ROW_W  top row of the K-row slice being read.
- rd_col  out  COL_W  column being read.
- win_valid  out  1  buffer output slice valid for the PE array.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE.
  - All outputs are 0: in_ready, buf_en, wr, rd, win_valid, busy, done.
  - All address counters are 0.
  - Reset mid-operation aborts immediately. No partial completion; done is not pulsed.
- States: IDLE, LOAD, SCAN, FLUSH, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1 -> LOAD, with wr_row = wr_col = 0.
  - start is ignored in every other state.
- LOAD:
  - in_ready = 1.
  - wr = buf_en = in_valid & in_ready, combinationally. Buffer captures at the same edge.
  - On each accepted beat wr_col increments. When wr_col = IMG_W-1 it wraps to 0 and wr_row increments.
  - in_valid low: counters hold, wr = 0.
  - Accepted beat at (IMG_H-1, IMG_W-1) -> SCAN next cycle; rd_row = rd_col = 0, in_ready falls.
  - Exactly IMG_H*IMG_W accepted beats per load.
- SCAN:
  - rd = buf_en = pe_ready, combinationally.
  - On each rd beat rd_col increments. When rd_col = IMG_W-1 it wraps to 0 and rd_row increments.
  - Last slice is rd_row = IMG_H-K, rd_col = IMG_W-1. That beat -> FLUSH.
  - Total reads = (IMG_H-K+1)*IMG_W (960 at defaults).
  - rd_row never exceeds IMG_H-K.
- Buffer read latency is 1 cycle: win_valid is rd registered, so win_valid(t+1) = rd(t).
  - The PE array must sample data whenever win_valid = 1, independent of pe_ready in that cycle.
- FLUSH: one cycle so the last win_valid is emitted; buf_en = 0. -> DONE.
- DONE: done = 1 for exactly one cycle, busy = 1. -> IDLE.
- Simultaneous events:
  - start in DONE is ignored; a new start is accepted from the following IDLE cycle.
  - pe_ready toggling every cycle still produces exactly one slice per rd beat; no duplicated or skipped addresses.
- No read occurs in LOAD and no write occurs in SCAN. wr & rd is never 1.
- Write and read counters are independent registers. Counters are unsigned and wrap only under the rules above; there is no free-running overflow.

Decomposition:
- Shared package img_pkg holds:
  - Image/kernel constants: IMG_W, IMG_H, K.
  - Derived widths: ROW_W, COL_W.
  - State encoding: IDLE, LOAD, SCAN, FLUSH, DONE.
- One natural sub-module: rc_counter. A parameterised row/column counter with inc, clear, wrap-at-max and last-flag. It is instantiated twice, once for write and once for read.

Test Plan:
- Basic load: start, in_valid held 1 -> wr high for exactly 1024 cycles. Addresses (0,0)..(31,31) in row-major order. SCAN entered on cycle 1025.
- Gapped input: in_valid high one cycle in three -> still 1024 writes. No address repeats; wr_col wraps 31->0 with a wr_row increment.
- Full scan with pe_ready = 1 -> 960 rd beats. Final address rd_row = 29, rd_col = 31. 960 win_valid pulses, each one cycle after rd. done pulses exactly once, two cycles after the last rd.
- PE backpressure: pe_ready = 0 for 5 cycles at rd_row = 10, rd_col = 7 -> addresses hold, rd = 0. Resume at (10,7) with no skip.
- start asserted during LOAD and SCAN -> ignored, counters unaffected. Second start after done -> fresh load from (0,0).
- Asynchronous rst at rd_row = 15 mid-SCAN -> outputs 0 and IDLE without waiting for a clock edge. No done pulse. Next start restarts load at (0,0).
